pipe_int_mul_param: RTL and testbench
=====================================

// Module: pipe_int_mul_param
// PURPOSE
//  Parametrised pipelined integer multiplier. Successor to the fixed 32x32, 4-stage multiplier.
//  Adds configurable operand width and stage count, per-operation signed/unsigned mode, and
//  valid/ready handshakes with output backpressure. Sits between an operand producer and a
//  result consumer. Accepts one operation per cycle when not stalled.
// PARAMETERS
//  WIDTH   32  operand width in bits; product is 2*WIDTH bits
//  STAGES  4   pipeline depth and latency; WIDTH % STAGES == 0 required, STAGES >= 1
//  CNT_W   3   width of occupancy counter; must hold 0..STAGES
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset (0 = reset)
//  intA       in   WIDTH    multiplicand
//  intB       in   WIDTH    multiplier
//  op_signed  in   1        1 = two's-complement operands, 0 = unsigned; sampled with operands
//  in_val     in   1        operands valid
//  in_rdy     out  1        block can accept operands this cycle
//  longP      out  2*WIDTH  product; meaningful only while out_val = 1
//  out_val    out  1        result valid (commit)
//  out_rdy    in   1        consumer accepts result this cycle
//  inflight   out  CNT_W    count of valid stages in the pipe (0..STAGES)
// BEHAVIOUR
//  - Reset (reset = 0, any time, mid-operation included): all stage valids cleared, out_val = 0,
//    inflight = 0, longP = 0. Data in the pipe is discarded. in_rdy = 1 from the first cycle
//    after release.
//  - Pipe: stages S0..S(STAGES-1), each holding valid, sign flag, |A|, |B|, and partial sum.
//    CHUNK = WIDTH/STAGES.
//    Stage i adds (|A| * |B|[i*CHUNK +: CHUNK]) << (i*CHUNK) to the partial sum.
//  - Signed mode: magnitudes are taken at S0 entry. A sign flag (A[msb] ^ B[msb]) travels with
//    the op. Two's-complement negation of the 2*WIDTH sum happens when writing S(STAGES-1).
//    Unsigned mode: sign flag = 0 and no magnitude conversion.
//  - Arithmetic: product is exact in 2*WIDTH bits; no overflow or truncation in either mode.
//    Edge case: (-2^(W-1)) * (-2^(W-1)) = +2^(2W-2).
//  - Handshake: a transfer occurs in any cycle where val && rdy. Inputs are held stable by the
//    producer until accepted. longP and out_val are held stable until accepted.
//  - Stall rule: stall = out_val & ~out_rdy. While stalled, no stage advances and in_rdy = 0.
//    Otherwise every stage shifts forward one place and in_rdy = 1.
//    in_rdy must not depend on in_val.
//  - Bubbles: when not stalled and in_val = 0, a bubble (valid = 0) enters S0. Bubbles are not
//    collapsed.
//  - Latency: an op accepted in cycle n with no stall gives out_val = 1 in cycle n+STAGES.
//    Each stall cycle adds one cycle. Throughput is 1 op/cycle with out_rdy held high.
//  - Ordering: results leave strictly in acceptance order.
//  - out_val = S(STAGES-1).valid; longP = S(STAGES-1).sum.
//  - inflight counts the stage valids: +1 on input accept, -1 on output accept, unchanged when
//    both or neither occur. It equals STAGES when the pipe is full.
//  - Simultaneous output accept and input accept in the same cycle is legal and loses no data.
//  - Full pipe with out_rdy = 0: in_rdy = 0 and no op is dropped. Once out_rdy = 1, the pipe
//    drains at 1 op/cycle.
// TESTING
//  1. Reset: reset=0 for 2 cycles -> out_val=0, inflight=0, longP=0; after release in_rdy=1.
//  2. Unsigned, WIDTH=32: A=0xFFFFFFFF, B=0xFFFFFFFF, accepted cycle n
//     -> cycle n+4: out_val=1, longP=0xFFFFFFFE00000001.
//  3. Signed: A=-3, B=7 -> longP=-21 (0xFFFF_FFFF_FFFF_FFEB).
//     A=0x80000000, B=0x80000000 -> longP=0x4000000000000000.
//  4. Back-to-back: 8 ops on consecutive cycles with out_rdy=1
//     -> 8 results on consecutive cycles n+4..n+11, in order.
//  5. Backpressure: fill pipe with out_rdy=0 -> in_rdy=0, inflight=4, longP held stable.
//     Raise out_rdy -> 4 results, none lost or duplicated.
//  6. Reset mid-operation with inflight=3 -> all valids cleared immediately; no stale result
//     after release. Also run sweeps with random ops and random out_rdy at WIDTH=16, STAGES=1/2/8
//     against a reference model.

Source files
------------

// File: rtl/pipe_int_mul_param.sv
// Pipelined integer multiplier with configurable width and depth, signed/unsigned per op,
// and valid/ready handshakes. Each stage folds one CHUNK-wide slice of |B| into the sum.
module pipe_int_mul_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     intA,
    input  logic [WIDTH-1:0]     intB,
    input  logic                 op_signed,
    input  logic                 in_val,
    output logic                 in_rdy,
    output logic [2*WIDTH-1:0]   longP,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [CNT_W-1:0]     inflight
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned PW    = 2 * WIDTH;

    // |a| times slice idx of |b|, aligned to its weight in the full product.
    function automatic logic [PW-1:0] partial(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input int unsigned      idx);
        logic [CHUNK-1:0] c;
        c = b[idx*CHUNK +: CHUNK];
        return (PW'(a) * PW'(c)) << (idx * CHUNK);
    endfunction

    logic              stall;
    logic              in_acc;
    logic              out_acc;
    logic              neg_a;
    logic              neg_b;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;

    logic [STAGES-1:0] vld_d, vld_q;
    logic              sgn_d [STAGES];
    logic              sgn_q [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [PW-1:0]     sum_d [STAGES];
    logic [PW-1:0]     sum_q [STAGES];
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        stall   = vld_q[STAGES-1] & ~out_rdy;
        in_acc  = in_val & ~stall;
        out_acc = vld_q[STAGES-1] & out_rdy;
        neg_a   = op_signed & intA[WIDTH-1];
        neg_b   = op_signed & intB[WIDTH-1];
        mag_a   = neg_a ? -intA : intA;
        mag_b   = neg_b ? -intB : intB;

        vld_d = vld_q;
        sgn_d = sgn_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (!stall) begin
            vld_d[0] = in_val;
            sgn_d[0] = neg_a ^ neg_b;
            a_d[0]   = mag_a;
            b_d[0]   = mag_b;
            sum_d[0] = partial(mag_a, mag_b, 0);
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                sgn_d[i] = sgn_q[i-1];
                a_d[i]   = a_q[i-1];
                b_d[i]   = b_q[i-1];
                sum_d[i] = sum_q[i-1] + partial(a_q[i-1], b_q[i-1], i);
            end
            // Sign is applied once, on entry to the final stage.
            if (sgn_d[STAGES-1]) begin
                sum_d[STAGES-1] = -sum_d[STAGES-1];
            end
        end

        cnt_d = cnt_q;
        if (in_acc && !out_acc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!in_acc && out_acc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                sgn_q[i] <= 1'b0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            sgn_q <= sgn_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
        end
    end

    always_comb begin
        in_rdy   = ~stall;
        out_val  = vld_q[STAGES-1];
        longP    = sum_q[STAGES-1];
        inflight = cnt_q;
    end

endmodule

// File: tb/tb_pipe_int_mul_param.sv
// Bench for pipe_int_mul_param: directed 32x32/4-stage scenarios plus randomised
// 16-bit sweeps at 1, 2 and 8 stages, all scored against a queue of model products.
module tb_pipe_int_mul_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        sgn, in_val, in_rdy, out_val, out_rdy;
    logic [63:0] p;
    logic [2:0]  infl;

    logic [2:0][15:0] sw_a, sw_b;
    logic [2:0]       sw_s, sw_val, sw_ordy, sw_irdy, sw_oval;
    logic [2:0][31:0] sw_p;
    logic [2:0][3:0]  sw_infl;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    pipe_int_mul_param #(.WIDTH(32), .STAGES(4), .CNT_W(3)) u_dut (
        .clk(clk), .reset(rst_n), .intA(a), .intB(b), .op_signed(sgn),
        .in_val(in_val), .in_rdy(in_rdy), .longP(p), .out_val(out_val),
        .out_rdy(out_rdy), .inflight(infl)
    );

    for (genvar k = 0; k < 3; k++) begin : g_sw
        localparam int unsigned SwSt = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
        pipe_int_mul_param #(.WIDTH(16), .STAGES(SwSt), .CNT_W(4)) u_sw (
            .clk(clk), .reset(rst_n), .intA(sw_a[k]), .intB(sw_b[k]), .op_signed(sw_s[k]),
            .in_val(sw_val[k]), .in_rdy(sw_irdy[k]), .longP(sw_p[k]), .out_val(sw_oval[k]),
            .out_rdy(sw_ordy[k]), .inflight(sw_infl[k])
        );
    end

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{32{x[31]}}, x} : {32'b0, x};
        ey = s ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
        logic [31:0] ex, ey;
        ex = s ? {{16{x[15]}}, x} : {16'b0, x};
        ey = s ? {{16{y[15]}}, y} : {16'b0, y};
        return ex * ey;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        a = '0; b = '0; sgn = 1'b0;
        sw_a = '0; sw_b = '0; sw_s = '0; sw_val = '0; sw_ordy = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_val = 1'b0; out_rdy = 1'b0; a = '0; b = '0; sgn = 1'b0;
        sw_a = '0; sw_b = '0; sw_s = '0; sw_val = '0; sw_ordy = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_val !== 1'b0) begin n_err++; $display("FAIL reset_out_val got %b want 0", out_val); end
        n_cmp++;
        if (infl !== 3'd0) begin n_err++; $display("FAIL reset_inflight got %0d want 0", infl); end
        n_cmp++;
        if (p !== 64'd0) begin n_err++; $display("FAIL reset_longP got %h want 0", p); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    endtask

    task automatic test_unsigned_max();
        int first_out = -1;
        logic [63:0] exp;
        do_reset();
        out_rdy = 1'b1;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sgn = 1'b0; in_val = 1'b1;
        sb.push_back(64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        in_val = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) begin
                n_cmp++;
                if (infl !== 3'd1) begin n_err++; $display("FAIL umax_inflight got %0d want 1", infl); end
            end
            if (out_val === 1'b1) begin
                if (first_out < 0) first_out = c;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL umax_extra got %h want none", p);
                end else begin
                    exp = sb.pop_front();
                    if (p !== exp) begin n_err++; $display("FAIL umax_value got %h want %h", p, exp); end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (first_out != 4) begin n_err++; $display("FAIL umax_latency got %0d want 4", first_out); end
    endtask

    task automatic test_signed();
        logic [31:0] oa [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0007,
                                32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] ob [5] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFD,
                                32'h8000_0000, 32'hFFFF_FFFF};
        logic        os [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] oe [5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                                64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                                64'h0000_0000_0000_0001};
        int idx = 0;
        int nout = 0;
        logic [63:0] exp;
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_val = (idx < 5);
            if (idx < 5) begin a = oa[idx]; b = ob[idx]; sgn = os[idx]; end
            #1;
            if (out_val && out_rdy) begin
                n_cmp++;
                nout++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL signed_extra got %h want none", p);
                end else begin
                    exp = sb.pop_front();
                    if (p !== exp) begin n_err++; $display("FAIL signed_value got %h want %h", p, exp); end
                end
            end
            if (in_val && in_rdy) begin sb.push_back(oe[idx]); idx++; end
            @(negedge clk);
        end
        in_val = 1'b0;
        n_cmp++;
        if (nout != 5) begin n_err++; $display("FAIL signed_count got %0d want 5", nout); end
    endtask

    task automatic test_back_to_back();
        int nout = 0;
        int rdy_bad = 0;
        logic [63:0] exp;
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_val = (c < 8);
            a = 32'h1234_5678 * (c + 1); b = 32'hDEAD_0000 + c; sgn = c[0];
            #1;
            if (in_rdy !== 1'b1) rdy_bad++;
            if (out_val === 1'b1) begin
                n_cmp++;
                if (c != nout + 4) begin
                    n_err++; $display("FAIL b2b_timing got cycle %0d want %0d", c, nout + 4);
                end
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
                if (p !== exp) begin n_err++; $display("FAIL b2b_value got %h want %h", p, exp); end
                nout++;
            end
            if (in_val && in_rdy) sb.push_back(ref32(a, b, sgn));
            @(negedge clk);
        end
        in_val = 1'b0;
        n_cmp++;
        if (nout != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", nout); end
        n_cmp++;
        if (rdy_bad != 0) begin n_err++; $display("FAIL b2b_in_rdy got %0d low cycles want 0", rdy_bad); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int nout = 0;
        logic [63:0] exp;
        do_reset();
        out_rdy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c >= 8) out_rdy = 1'b1;
            in_val = (idx < 5);
            a = 32'hF000_0001 + idx; b = 32'h0001_0003 * (idx + 2); sgn = 1'b1;
            #1;
            if (c >= 4 && c < 8) begin
                n_cmp++;
                if (in_rdy !== 1'b0 || infl !== 3'd4 || out_val !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_full got in_rdy=%b inflight=%0d out_val=%b want 0/4/1",
                             in_rdy, infl, out_val);
                end
                n_cmp++;
                exp = (sb.size() != 0) ? sb[0] : 64'hx;
                if (p !== exp) begin n_err++; $display("FAIL bp_held got %h want %h", p, exp); end
            end
            if (out_val && out_rdy) begin
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
                if (p !== exp) begin n_err++; $display("FAIL bp_drain got %h want %h", p, exp); end
                nout++;
            end
            if (in_val && in_rdy) begin sb.push_back(ref32(a, b, sgn)); idx++; end
            @(negedge clk);
        end
        in_val = 1'b0;
        n_cmp++;
        if (nout != 5 || sb.size() != 0) begin
            n_err++; $display("FAIL bp_count got %0d out %0d left want 5 out 0 left", nout, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_val = 1'b1; a = 32'h0BAD_CAFE + c; b = 32'h7777_0000 + c; sgn = 1'b0;
            @(negedge clk);
        end
        in_val = 1'b0;
        #1;
        n_cmp++;
        if (infl !== 3'd3) begin n_err++; $display("FAIL mid_inflight got %0d want 3", infl); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (infl !== 3'd0 || out_val !== 1'b0 || p !== 64'd0) begin
            n_err++;
            $display("FAIL mid_clear got inflight=%0d out_val=%b longP=%h want 0/0/0", infl, out_val, p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_val !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0) begin n_err++; $display("FAIL mid_stale got %0d valid cycles want 0", stale); end
    endtask

    task automatic test_sweep(input int k);
        logic [31:0] q[$];
        logic [31:0] exp;
        logic        need_new = 1'b1;
        logic        acc;
        int          nout = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (need_new) begin
                sw_val[k] = (c < 300) && ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       sw_a[k] = 16'h8000;
                    1:       sw_a[k] = 16'hFFFF;
                    default: sw_a[k] = 16'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       sw_b[k] = 16'h8000;
                    1:       sw_b[k] = 16'hFFFF;
                    default: sw_b[k] = 16'($urandom);
                endcase
                sw_s[k] = 1'($urandom_range(0, 1));
            end
            sw_ordy[k] = (c >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (sw_infl[k] !== 4'(q.size())) begin
                n_err++; $display("FAIL sweep%0d_inflight got %0d want %0d", k, sw_infl[k], q.size());
            end
            if (sw_oval[k] && sw_ordy[k]) begin
                n_cmp++;
                nout++;
                exp = (q.size() != 0) ? q.pop_front() : 32'hx;
                if (sw_p[k] !== exp) begin
                    n_err++; $display("FAIL sweep%0d_value got %h want %h", k, sw_p[k], exp);
                end
            end
            acc = sw_val[k] && sw_irdy[k];
            if (acc) q.push_back(ref16(sw_a[k], sw_b[k], sw_s[k]));
            need_new = !sw_val[k] || acc;
            @(negedge clk);
        end
        n_cmp++;
        if (q.size() != 0 || nout == 0) begin
            n_err++; $display("FAIL sweep%0d_drain got %0d left %0d out want 0 left", k, q.size(), nout);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        for (int k = 0; k < 3; k++) test_sweep(k);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
